// File: rtl/beta_pkg.sv
// Shared types and defaults for the Beta decode-stage register file and its
// in-flight destination tag pipeline.
package beta_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_NREGS   = 32;
  localparam int DEF_NSTAGES = 3;
  localparam int REG_ZERO    = DEF_NREGS - 1;

  // Tags carry a fixed-width register field so that any NREGS up to 256 fits.
  localparam int TAG_AW = 8;

  typedef struct packed {
    logic              valid;
    logic [TAG_AW-1:0] rc;
    logic              is_load;
  } rf_tag_t;

endpackage

// File: rtl/beta_rf_hazard_tag_pipe.sv
// rf_tag_pipe: shift register of destination tags for instructions past decode.
// Slot 0 is exec; a flush kills the tag leaving slot 0 as it moves to slot 1.
module rf_tag_pipe
  import beta_pkg::*;
#(
  parameter int NSTAGES = DEF_NSTAGES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  rf_tag_t                ins,
  input  logic                   flush,
  output rf_tag_t [NSTAGES-1:0]  tags
);

  rf_tag_t [NSTAGES-1:0] tags_r;

  // tag shift register: insert at exec, age toward wb, drop the oldest
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tags_r <= '0;
    end else begin
      tags_r[0]       <= ins;
      tags_r[1]       <= tags_r[0];
      tags_r[1].valid <= tags_r[0].valid & ~flush;
      for (int i = 2; i < NSTAGES; i++) begin
        tags_r[i] <= tags_r[i-1];
      end
    end
  end

  assign tags = tags_r;

endmodule

// File: rtl/beta_rf_hazard.sv
// beta_rf_hazard: decode-stage register file with hazard tracking, zero register,
// write-through and load-use stall. Stage forwarding is built when BETA_RF_BYPASS_EN is defined.
module beta_rf_hazard
  import beta_pkg::*;
#(
  parameter  int DATA_W  = DEF_DATA_W,
  parameter  int NREGS   = DEF_NREGS,
  parameter  int NSTAGES = DEF_NSTAGES,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            dec_valid,
  input  logic [AW-1:0]                   dec_ra,
  input  logic [AW-1:0]                   dec_rb,
  input  logic [AW-1:0]                   dec_rc,
  input  logic                            dec_use_rb,
  input  logic                            dec_writes,
  input  logic                            dec_is_load,
  input  logic                            flush,
  output logic                            stall,
  output logic [DATA_W-1:0]               rd1,
  output logic [DATA_W-1:0]               rd2,
  input  logic [NSTAGES-1:0][DATA_W-1:0]  byp_data,
  input  logic                            we,
  input  logic [AW-1:0]                   wa,
  input  logic [DATA_W-1:0]               wd
);

  localparam int            SW       = $clog2(NSTAGES);
  localparam logic [AW-1:0] ZERO_IDX = AW'(NREGS - 1);
  localparam logic [SW-1:0] LAST     = SW'(NSTAGES - 1);

  logic [DATA_W-1:0]     regs_r [NREGS-1];
  rf_tag_t [NSTAGES-1:0] tags_s;
  rf_tag_t               ins_s;
  logic                  stall_s;
  logic [AW-1:0]         src_s   [2];
  logic [1:0]            en_s;
  logic [1:0]            found_s;
  logic [1:0]            ld_s;
  logic [1:0]            haz_s;
  logic [SW-1:0]         idx_s   [2];
  logic [DATA_W-1:0]     base_s  [2];
  logic [DATA_W-1:0]     val_s   [2];

  // Youngest in-flight stage writing s; scanning oldest-first lets the youngest overwrite.
  function automatic void find_hit(
    input  logic [AW-1:0]         s,
    input  logic                  en,
    input  rf_tag_t [NSTAGES-1:0] tags,
    output logic                  found,
    output logic [SW-1:0]         idx,
    output logic                  ld
  );
    logic m;
    found = 1'b0;
    idx   = '0;
    ld    = 1'b0;
    for (int i = NSTAGES - 1; i >= 0; i--) begin
      m     = en && tags[i].valid && (tags[i].rc == TAG_AW'(s)) && (s != ZERO_IDX);
      found = found | m;
      idx   = m ? SW'(i) : idx;
      ld    = m ? tags[i].is_load : ld;
    end
  endfunction

  assign src_s[0] = dec_ra;
  assign src_s[1] = dec_rb;
  assign en_s     = {dec_use_rb, 1'b1};

  // operand resolution: stage match, then write-through, then array
  always_comb begin
    found_s = 2'b00;
    ld_s    = 2'b00;
    haz_s   = 2'b00;
    for (int s = 0; s < 2; s++) begin
      idx_s[s]  = '0;
      base_s[s] = '0;
      val_s[s]  = '0;
      find_hit(src_s[s], en_s[s], tags_s, found_s[s], idx_s[s], ld_s[s]);
      if (src_s[s] == ZERO_IDX) begin
        base_s[s] = '0;
      end else if (we && (wa == src_s[s])) begin
        base_s[s] = wd;
      end else begin
        base_s[s] = regs_r[src_s[s]];
      end
`ifdef BETA_RF_BYPASS_EN
      // only a load still short of wb has no result to forward yet
      haz_s[s] = found_s[s] && ld_s[s] && (idx_s[s] != LAST);
      val_s[s] = (found_s[s] && (!ld_s[s] || (idx_s[s] == LAST))) ? byp_data[idx_s[s]] : base_s[s];
`else
      // a wb-stage producer is writing this cycle, so write-through covers it
      haz_s[s] = found_s[s] && (idx_s[s] != LAST);
      val_s[s] = base_s[s];
`endif
    end
  end

`ifndef BETA_RF_BYPASS_EN
  logic unused_s;
  assign unused_s = ^{byp_data, ld_s};
`endif

  assign stall_s = dec_valid & ~flush & (|haz_s);
  assign ins_s   = '{valid:   dec_valid & dec_writes & ~stall_s & ~flush,
                     rc:      TAG_AW'(dec_rc),
                     is_load: dec_is_load};

  // architectural storage; R31 has no flop and writes to it are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS - 1; i++) begin
        regs_r[i] <= '0;
      end
    end else if (we && (wa != ZERO_IDX)) begin
      regs_r[wa] <= wd;
    end
  end

  rf_tag_pipe #(.NSTAGES(NSTAGES)) u_tag_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .ins   (ins_s),
    .flush (flush),
    .tags  (tags_s)
  );

  assign stall = stall_s;
  assign rd1   = val_s[0];
  assign rd2   = val_s[1];

endmodule

// File: tb/tb_beta_rf_hazard.sv
// Directed table-driven bench for beta_rf_hazard (NSTAGES = 3); expectations
// follow whichever build of BETA_RF_BYPASS_EN is compiled.
module tb_beta_rf_hazard;

`ifdef BETA_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             dec_valid, dec_use_rb, dec_writes, dec_is_load, flush, we;
  logic [4:0]       dec_ra, dec_rb, dec_rc, wa;
  logic [31:0]      wd, rd1, rd2;
  logic             stall;
  logic [2:0][31:0] byp_data;

  typedef struct {
    logic             v, urb, wr, ld, fl, we;
    logic [4:0]       ra, rb, rc, wa;
    logic [31:0]      wd;
    logic [2:0][31:0] byp;
    logic             xs;
    logic [31:0]      x1, x2;
  } vec_t;

  vec_t  vecs  [$];
  string names [$];
  int    n_vec = 0;
  int    n_err = 0;

  beta_rf_hazard dut (
    .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_ra(dec_ra), .dec_rb(dec_rb),
    .dec_rc(dec_rc), .dec_use_rb(dec_use_rb), .dec_writes(dec_writes),
    .dec_is_load(dec_is_load), .flush(flush), .stall(stall), .rd1(rd1), .rd2(rd2),
    .byp_data(byp_data), .we(we), .wa(wa), .wd(wd)
  );

  always #5 clk = ~clk;

  function automatic vec_t op(logic v, logic [4:0] ra, logic [4:0] rb, logic [4:0] rc,
                              logic urb, logic wr, logic ld, logic fl,
                              logic xs, logic [31:0] x1, logic [31:0] x2);
    vec_t t;
    t.v = v; t.ra = ra; t.rb = rb; t.rc = rc; t.urb = urb; t.wr = wr; t.ld = ld; t.fl = fl;
    t.we = 1'b0; t.wa = 5'd0; t.wd = 32'd0; t.byp = '0;
    t.xs = xs; t.x1 = x1; t.x2 = x2;
    return t;
  endfunction

  task automatic add(input string nm, input vec_t t);
    names.push_back(nm);
    vecs.push_back(t);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) add("drain", op(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0));
  endtask

  task automatic drive(input vec_t t);
    dec_valid = t.v; dec_ra = t.ra; dec_rb = t.rb; dec_rc = t.rc; dec_use_rb = t.urb;
    dec_writes = t.wr; dec_is_load = t.ld; flush = t.fl;
    we = t.we; wa = t.wa; wd = t.wd; byp_data = t.byp;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    vec_t t;
    // reset contents: every register reads zero
    for (int r = 0; r < 32; r++)
      add($sformatf("rst_r%0d", r), op(1'b0, 5'(r), 5'(r), 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0));
    t = op(1'b0, 5'd31, 5'd31, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    t.we = 1'b1; t.wa = 5'd31; t.wd = 32'hDEADBEEF;
    add("w_r31", t);
    add("r_r31", op(1'b0, 5'd31, 5'd31, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0));
    t = op(1'b0, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h66, 32'd0);
    t.we = 1'b1; t.wa = 5'd6; t.wd = 32'h66;
    add("wt_r6", t);
    add("r_r6", op(1'b0, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h66, 32'd0));
    // ADD R1 ; SUB R2,R1,R1
    add("add_r1", op(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0));
    t = op(1'b1, 5'd1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, !BYP, BYP ? 32'h5 : 32'd0, BYP ? 32'h5 : 32'd0);
    t.byp[0] = 32'h5;
    add("sub_r2", t);
    if (!BYP) begin
      t = op(1'b1, 5'd1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
      t.byp[1] = 32'h5;
      add("sub_r2_s2", t);
      t = op(1'b1, 5'd1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h5, 32'h5);
      t.byp[2] = 32'h5; t.we = 1'b1; t.wa = 5'd1; t.wd = 32'h5;
      add("sub_r2_wb", t);
    end
    drain();
    // LD R3 ; ADD R4,R3,R0
    add("ld_r3", op(1'b1, 5'd0, 5'd0, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0));
    add("use_r3_s1", op(1'b1, 5'd3, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0));
    add("use_r3_s2", op(1'b1, 5'd3, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0));
    t = op(1'b1, 5'd3, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1234, 32'd0);
    t.byp[2] = 32'h1234; t.we = 1'b1; t.wa = 5'd3; t.wd = 32'h1234;
    add("use_r3_go", t);
    drain();
    // R5 in exec and mem: youngest wins
    add("w5_a", op(1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0));
    add("w5_b", op(1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0));
    t = op(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, !BYP, BYP ? 32'hA : 32'd0, BYP ? 32'hA : 32'd0);
    t.byp[0] = 32'hA; t.byp[1] = 32'hB;
    add("r5_young", t);
    drain();
    // load R6 killed by flush
    add("ld_r6", op(1'b1, 5'd0, 5'd0, 5'd6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0));
    add("flush", op(1'b1, 5'd6, 5'd0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h66, 32'd0));
    add("after_flush", op(1'b1, 5'd6, 5'd0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h66, 32'd0));
    drain();
    // Rb hazard only counts when Rb is used
    add("ld_r9", op(1'b1, 5'd0, 5'd0, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0));
    add("rb_unused", op(1'b1, 5'd0, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0));
    add("rb_used", op(1'b1, 5'd0, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0));
    drain();
    // R31 destination never creates a hazard
    add("ld_r31", op(1'b1, 5'd0, 5'd0, 5'd31, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0));
    add("use_r31", op(1'b1, 5'd31, 5'd31, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0));
    drain();

    drive(op(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0));
    rst_n = 1'b0;
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      drive(vecs[k]);
      #2;
      chk({names[k], ".stall"}, {31'd0, stall}, {31'd0, vecs[k].xs});
      chk({names[k], ".rd1"}, rd1, vecs[k].x1);
      chk({names[k], ".rd2"}, rd2, vecs[k].x2);
    end

    // asynchronous reset while a load-use stall is pending
    @(negedge clk);
    drive(op(1'b1, 5'd0, 5'd0, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0));
    @(negedge clk);
    drive(op(1'b1, 5'd7, 5'd6, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0));
    #2;
    chk("pre_rst.stall", {31'd0, stall}, 32'd1);
    chk("pre_rst.rd2", rd2, 32'h66);
    #1;
    rst_n = 1'b0;
    #1;
    chk("in_rst.stall", {31'd0, stall}, 32'd0);
    chk("in_rst.rd2", rd2, 32'd0);
    dec_valid = 1'b0; we = 1'b1; wa = 5'd10; wd = 32'hFF;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    we = 1'b0;
    for (int r = 1; r <= 10; r++) begin
      @(negedge clk);
      dec_ra = 5'(r); dec_rb = 5'(r); dec_use_rb = 1'b1;
      #2;
      chk($sformatf("post_rst_r%0d", r), rd1, 32'd0);
    end
    chk("post_rst.stall", {31'd0, stall}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/beta_rf_hazard.md
# beta_rf_hazard

Parametrised register file with an internal hazard tracker for the Beta pipeline. It sits in the decode stage and serves the operand reads for the instruction in decode. It tracks the destination tags of in-flight instructions in its own shift pipeline, so it needs no instruction registers from the later stages. It forwards stage results, stalls decode on load-use hazards, hardwires the zero register and supports a kill of the youngest instructions.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- NREGS, 32, number of architectural registers; address width AW = $clog2(NREGS)
- NSTAGES, 3, in-flight stages after decode (index 0 = exec, NSTAGES-1 = wb); must be ≥ 2

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst_n  in  1  reset; **asynchronous, active-low**
- dec_valid  in  1  a valid instruction is in decode
- dec_ra, dec_rb, dec_rc  in  AW each  source and destination addresses in decode
- dec_use_rb  in  1  instruction reads Rb (OP class)
- dec_writes  in  1  instruction writes Rc
- dec_is_load  in  1  instruction is LD/LDR
- flush  in  1  kill the decode instruction and the exec-stage tag
- stall  out  1  hold decode; a bubble enters exec
- rd1, rd2  out  DATA_W each  operand values for Ra and Rb
- byp_data  in  NSTAGES×DATA_W  result currently held in each stage
- we  in  1  architectural write enable, driven from wb
- wa  in  AW  write address
- wd  in  DATA_W  write data

## Operation
- Storage: NREGS-1 flops. Address NREGS-1 (R31) always reads 0. Writes to R31 are dropped. R31 never matches a hazard.
- Tag pipeline: NSTAGES entries of {valid, rc, is_load}. Each cycle entry i moves to i+1, and entry NSTAGES-1 is discarded.
- Entry 0 loads {dec_valid & dec_writes & !stall & !flush, dec_rc, dec_is_load}. It loads a bubble (valid = 0) on stall or flush.
- flush also clears the valid bit of the entry currently in slot 0 before it shifts to slot 1.
- Match: stage i matches source s when valid_i, rc_i == s and s ≠ R31. Rb is checked only when dec_use_rb is set.
- Forward: the youngest matching stage wins (lowest i). A non-load match at stage i gives byp_data[i].
- A load match at stage NSTAGES-1 gives byp_data[NSTAGES-1].
- With no stage match, a read with we && wa == s gives wd (write-through). Otherwise the read gives the array value.
- stall = dec_valid & !flush & (any youngest match on a used source is a load in a stage < NSTAGES-1).
- Simultaneous stall and flush: flush wins and stall = 0.

## Timing
- rd1, rd2 and stall are combinational from the tag state and the inputs, with zero cycles of latency.
- Array writes take effect at the clk edge. A read in the same cycle sees wd through write-through.
- Load-use spacing:
  - Consumer directly behind a load: stalls NSTAGES-1 cycles.
  - One instruction between them: stalls NSTAGES-2 cycles.
- Reset values:
  - All registers hold 0.
  - All tags are invalid.
  - stall = 0, and rd1 = rd2 = 0 unless bypassed by wd.
- rst_n asserted mid-operation clears everything immediately. Pending hazards are forgotten and no write completes during reset.

## Configuration
- BETA_RF_BYPASS_EN defined: forwarding as described above.
- Not defined: no byp_data forwarding. Any valid match in any stage stalls, regardless of load. Write-through stays.
- The byp_data port remains in both builds and is ignored when the macro is not defined.

## Structure
- beta_pkg holds:
  - rf_tag_t struct {valid, rc, is_load}
  - REG_ZERO = NREGS-1
  - default DATA_W, NREGS and NSTAGES
- Sub-module rf_tag_pipe: the NSTAGES shift register with insert, bubble and flush. It has the same async active-low reset.
- The top level holds the storage array, the match/priority logic and stall.

## Test plan
- After reset, read R0..R31 → all read 0 and stall = 0. Write R31 = 0xDEADBEEF → R31 still reads 0.
- ADD R1 then SUB R2,R1,R1 back-to-back: exec byp_data = 0x5 → rd1 = rd2 = 0x5 with no stall. With the macro undefined → 2 stall cycles (NSTAGES = 3).
- LD R3 then ADD R4,R3,R0 → stall high for 2 cycles, then rd1 = byp_data[wb] = 0x1234.
- R5 in both exec (0xA) and mem (0xB) → rd1 = 0xA (youngest wins).
- Load R6 in exec with flush asserted → stall = 0, the exec tag is invalidated, and the next cycle's consumer of R6 reads the array.
- rst_n pulsed low while stall = 1 → stall drops asynchronously and all registers read 0 after reset.
